cdc_ctrl_fsm_p: RTL and testbench

Parametrised next-generation control FSM for the CDC demo design. It brings asynchronous control strobes and interrupt requests into the clk domain through N-stage synchronisers, then edge-detects them. It sequences a FIFO read/load cycle, with a configurable wait threshold and multi-channel prioritised interrupts that resume the interrupted state. It sits between the async control/FIFO interface and downstream data consumers.

---
 rtl/cdc_ctrl_pkg.sv | 19 +
 rtl/cdc_ctrl_fsm_p_sync.sv | 29 ++
 rtl/cdc_ctrl_fsm_p.sv | 197 +++++++++++++++++++
 tb/tb_cdc_ctrl_fsm_p.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cdc_ctrl_pkg.sv
// Shared definitions for the CDC control FSM: state codes and index-width helper.
package cdc_ctrl_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] S_WAIT     = 3'd1;
   localparam logic [STATE_W-1:0] S_READ     = 3'd2;
   localparam logic [STATE_W-1:0] S_LOAD     = 3'd3;
   localparam logic [STATE_W-1:0] S_ERROR    = 3'd4;
   localparam logic [STATE_W-1:0] S_INT_ACK  = 3'd5;
   localparam logic [STATE_W-1:0] S_INT_HOLD = 3'd6;

   // Bits needed to index n items, never less than one.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cdc_ctrl_fsm_p_sync.sv
// N-stage synchroniser with a one-cycle rising-edge pulse on the synchronised level.
module sync_edge_p #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic pulse_c
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   q_d;

   // Shift the async level through the chain and keep a delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         q_d   <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
         q_d   <= chain[SYNC_STAGES-1];
      end
   end

   assign q       = chain[SYNC_STAGES-1];
   assign pulse_c = q & ~q_d;

endmodule

// File: rtl/cdc_ctrl_fsm_p.sv
// Control FSM: synchronised strobes, FIFO read/load sequencing, prioritised interrupts.
module cdc_ctrl_fsm_p
   import cdc_ctrl_pkg::*;
#(
   parameter int unsigned         DATA_W       = 32,
   parameter int unsigned         SYNC_STAGES  = 2,
   parameter int unsigned         NUM_INT      = 4,
   parameter int unsigned         CNT_W        = 3,
   parameter int unsigned         WAIT_COUNT   = 7,
   parameter int unsigned         INT_HOLD_CYC = 2,
   parameter logic [DATA_W-1:0]   MAGIC_IN     = DATA_W'(32'h1111),
   parameter logic [DATA_W-1:0]   MAGIC_OUT    = DATA_W'(32'h55AA)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ctrl_count,
   input  logic                        ctrl_step,
   input  logic                        error_sig,
   input  logic                        clear_err,
   input  logic [NUM_INT-1:0]          int_req,
   input  logic                        fifo_empty,
   input  logic [DATA_W-1:0]           fifo_data,
   output logic                        read_en,
   output logic [DATA_W-1:0]           data_out,
   output logic                        data_valid,
   output logic [CNT_W-1:0]            count_out,
   output logic [STATE_W-1:0]          state_out,
   output logic [idx_w(NUM_INT)-1:0]   i_code,
   output logic                        i_valid,
   output logic                        err_flag
);

   localparam int unsigned IDX_W  = idx_w(NUM_INT);
   localparam int unsigned HOLD_W = idx_w(INT_HOLD_CYC + 1);

   logic [SYNC_STAGES-1:0] rst_pipe;
   logic                   rst_sync_n;

   logic                   count_q, count_pulse_c;
   logic                   step_q, step_pulse_c;
   logic                   error_sync, error_pulse_c;
   logic [NUM_INT-1:0]     int_sync, int_pulse_c;
   logic                   int_any_c;
   logic [IDX_W-1:0]       low_code_c;

   logic [STATE_W-1:0]     state, state_nxt;
   logic [STATE_W-1:0]     ret_state, ret_nxt;
   logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
   logic                   load_ph, load_ph_nxt;
   logic                   read_en_nxt, data_valid_nxt, i_valid_nxt, err_nxt;
   logic [DATA_W-1:0]      data_nxt;
   logic [IDX_W-1:0]       code_nxt;
   logic [CNT_W-1:0]       count_nxt;

   logic                   unused_sync;

   // Reset synchroniser: asserts asynchronously, releases SYNC_STAGES edges after rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_pipe <= '0;
      else        rst_pipe <= {rst_pipe[SYNC_STAGES-2:0], 1'b1};
   end

   assign rst_sync_n = rst_pipe[SYNC_STAGES-1];

   sync_edge_p #(.SYNC_STAGES(SYNC_STAGES)) u_sync_count (
      .clk(clk), .rst_n(rst_sync_n), .d(ctrl_count), .q(count_q), .pulse_c(count_pulse_c));

   sync_edge_p #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
      .clk(clk), .rst_n(rst_sync_n), .d(ctrl_step), .q(step_q), .pulse_c(step_pulse_c));

   sync_edge_p #(.SYNC_STAGES(SYNC_STAGES)) u_sync_error (
      .clk(clk), .rst_n(rst_sync_n), .d(error_sig), .q(error_sync), .pulse_c(error_pulse_c));

   for (genvar g = 0; g < NUM_INT; g++) begin : g_int
      sync_edge_p #(.SYNC_STAGES(SYNC_STAGES)) u_sync_int (
         .clk(clk), .rst_n(rst_sync_n), .d(int_req[g]), .q(int_sync[g]), .pulse_c(int_pulse_c[g]));
   end

   assign unused_sync = ^{count_q, step_q, error_pulse_c, int_pulse_c};
   assign int_any_c   = |int_sync;

   // Lowest-index active interrupt channel.
   always_comb begin
      low_code_c = '0;
      for (int i = NUM_INT - 1; i >= 0; i--) begin
         if (int_sync[i]) low_code_c = IDX_W'(i);
      end
   end

   // Next-state, counter and registered-output next values.
   always_comb begin
      state_nxt      = state;
      ret_nxt        = ret_state;
      hold_nxt       = hold_cnt;
      load_ph_nxt    = 1'b0;
      read_en_nxt    = 1'b0;
      data_valid_nxt = 1'b0;
      data_nxt       = data_out;
      code_nxt       = i_code;
      i_valid_nxt    = i_valid;
      count_nxt      = count_pulse_c ? count_out + 1'b1 : count_out;

      case (state)
         S_IDLE, S_WAIT, S_READ: begin
            if (int_any_c) begin
               state_nxt = S_INT_ACK;
               ret_nxt   = state;
            end else if (step_pulse_c) begin
               if (error_sync) begin
                  state_nxt = S_ERROR;
               end else if (state == S_IDLE) begin
                  state_nxt = S_WAIT;
               end else if (state == S_WAIT) begin
                  if (count_out >= CNT_W'(WAIT_COUNT)) begin
                     state_nxt = S_READ;
                     count_nxt = '0;
                  end
               end else if (!fifo_empty) begin
                  state_nxt   = S_LOAD;
                  read_en_nxt = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (!load_ph) begin
               load_ph_nxt = 1'b1;
            end else begin
               if (fifo_data == '0)            data_nxt = '1;
               else if (fifo_data == MAGIC_IN) data_nxt = MAGIC_OUT;
               else                            data_nxt = fifo_data;
               data_valid_nxt = 1'b1;
               if (int_any_c) begin
                  state_nxt = S_INT_ACK;
                  ret_nxt   = S_IDLE;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_INT_ACK: begin
            code_nxt    = low_code_c;
            i_valid_nxt = 1'b1;
            hold_nxt    = '0;
            state_nxt   = S_INT_HOLD;
         end
         S_INT_HOLD: begin
            if (hold_cnt == HOLD_W'(INT_HOLD_CYC - 1)) begin
               i_valid_nxt = 1'b0;
               state_nxt   = ret_state;
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         S_ERROR: begin
            if (clear_err) begin
               state_nxt = S_IDLE;
               count_nxt = '0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      err_nxt = (state_nxt == S_ERROR);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state      <= S_IDLE;
         ret_state  <= S_IDLE;
         hold_cnt   <= '0;
         load_ph    <= 1'b0;
         read_en    <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         count_out  <= '0;
         i_code     <= '0;
         i_valid    <= 1'b0;
         err_flag   <= 1'b0;
      end else begin
         state      <= state_nxt;
         ret_state  <= ret_nxt;
         hold_cnt   <= hold_nxt;
         load_ph    <= load_ph_nxt;
         read_en    <= read_en_nxt;
         data_out   <= data_nxt;
         data_valid <= data_valid_nxt;
         count_out  <= count_nxt;
         i_code     <= code_nxt;
         i_valid    <= i_valid_nxt;
         err_flag   <= err_nxt;
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_cdc_ctrl_fsm_p.sv
// Directed bench for cdc_ctrl_fsm_p with a queue-based output scoreboard.
module tb_cdc_ctrl_fsm_p;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned NUM_INT = 4;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned HOLD   = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               ctrl_count = 1'b0;
   logic               ctrl_step = 1'b0;
   logic               error_sig = 1'b0;
   logic               clear_err = 1'b0;
   logic [NUM_INT-1:0] int_req = '0;
   logic               fifo_empty = 1'b1;
   logic [DATA_W-1:0]  fifo_data = '0;

   logic               read_en;
   logic [DATA_W-1:0]  data_out;
   logic               data_valid;
   logic [CNT_W-1:0]   count_out;
   logic [2:0]         state_out;
   logic [IDX_W-1:0]   i_code;
   logic               i_valid;
   logic               err_flag;

   int vectors = 0;
   int miscompares = 0;
   int rd_cnt = 0;
   int iv_len = 0;
   logic iv_prev = 1'b0;

   logic [DATA_W-1:0] exp_data_q[$];
   logic [IDX_W-1:0]  exp_code_q[$];

   cdc_ctrl_fsm_p dut (
      .clk(clk), .rst_n(rst_n), .ctrl_count(ctrl_count), .ctrl_step(ctrl_step),
      .error_sig(error_sig), .clear_err(clear_err), .int_req(int_req),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .read_en(read_en),
      .data_out(data_out), .data_valid(data_valid), .count_out(count_out),
      .state_out(state_out), .i_code(i_code), .i_valid(i_valid), .err_flag(err_flag));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe_count();
      ctrl_count = 1'b1; cyc(3); ctrl_count = 1'b0; cyc(3);
   endtask

   task automatic strobe_step();
      ctrl_step = 1'b1; cyc(3); ctrl_step = 1'b0; cyc(3);
   endtask

   // From IDLE: step to WAIT, 7 counts, step to READ, then step to LOAD with given data.
   task automatic do_load(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp, input int rd_exp);
      strobe_step();
      check("to_wait", 32'(state_out), 32'd1);
      repeat (7) strobe_count();
      strobe_step();
      check("to_read", 32'(state_out), 32'd2);
      fifo_empty = 1'b0;
      fifo_data  = d;
      exp_data_q.push_back(exp);
      strobe_step();
      check("load_done_idle", 32'(state_out), 32'd0);
      check("read_en_count", 32'(rd_cnt), 32'(rd_exp));
   endtask

   // Scoreboard monitor: pops expectations when data_valid or i_valid present.
   always @(negedge clk) begin
      if (rst_n) begin
         if (read_en) rd_cnt++;
         if (data_valid) begin
            if (exp_data_q.size() == 0) check("unexpected_data_valid", data_out, 32'hDEAD_0000);
            else check("data_out", data_out, exp_data_q.pop_front());
         end
         if (i_valid && !iv_prev) begin
            if (exp_code_q.size() == 0) check("unexpected_i_valid", 32'(i_code), 32'hDEAD_0001);
            else check("i_code", 32'(i_code), 32'(exp_code_q.pop_front()));
            iv_len = 1;
         end else if (i_valid) begin
            iv_len++;
         end else if (iv_prev) begin
            check("i_valid_len", 32'(iv_len), 32'(HOLD));
         end
         iv_prev = i_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(3);
      check("rst_state", 32'(state_out), 32'd0);
      check("rst_count", 32'(count_out), 32'd0);
      check("rst_read_en", 32'(read_en), 32'd0);
      check("rst_data_valid", 32'(data_valid), 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_i_valid", 32'(i_valid), 32'd0);
      check("rst_err_flag", 32'(err_flag), 32'd0);

      // Step while the internal reset is still held must be lost.
      rst_n = 1'b1; ctrl_step = 1'b1; cyc(2); ctrl_step = 1'b0; cyc(4);
      check("step_in_rst_sync", 32'(state_out), 32'd0);

      strobe_step();
      check("idle_to_wait", 32'(state_out), 32'd1);
      repeat (6) strobe_count();
      check("count_6", 32'(count_out), 32'd6);
      strobe_step();
      check("wait_stays_6", 32'(state_out), 32'd1);
      check("wait_count_kept", 32'(count_out), 32'd6);

      // Interrupt from WAIT, channels 1 and 2 -> code 1.
      int_req = 4'b0110; exp_code_q.push_back(2'd1);
      cyc(2); int_req = '0; cyc(1);
      check("int_ack_state", 32'(state_out), 32'd5);
      cyc(1);
      check("int_hold_state", 32'(state_out), 32'd6);
      check("int_hold_i_valid", 32'(i_valid), 32'd1);
      cyc(1);
      check("int_hold_state2", 32'(state_out), 32'd6);
      cyc(1);
      check("int_return_wait", 32'(state_out), 32'd1);
      check("int_count_kept", 32'(count_out), 32'd6);
      check("i_code_held", 32'(i_code), 32'd1);
      cyc(3);

      strobe_count();
      check("count_7", 32'(count_out), 32'd7);
      strobe_step();
      check("wait_to_read", 32'(state_out), 32'd2);
      check("count_cleared", 32'(count_out), 32'd0);

      fifo_empty = 1'b1;
      strobe_step();
      check("read_empty_stays", 32'(state_out), 32'd2);
      check("no_read_en", 32'(rd_cnt), 32'd0);
      fifo_empty = 1'b0; fifo_data = 32'h0000_1111;
      exp_data_q.push_back(32'h0000_55AA);
      strobe_step();
      check("load1_idle", 32'(state_out), 32'd0);
      check("read_en_once", 32'(rd_cnt), 32'd1);

      do_load(32'h0000_0000, 32'hFFFF_FFFF, 2);
      do_load(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3);

      // Error path.
      repeat (2) strobe_count();
      check("count_2", 32'(count_out), 32'd2);
      error_sig = 1'b1; cyc(3);
      strobe_step();
      check("error_state", 32'(state_out), 32'd4);
      check("err_flag_set", 32'(err_flag), 32'd1);
      int_req = 4'b0001; cyc(6);
      check("error_ignores_int", 32'(state_out), 32'd4);
      check("error_no_i_valid", 32'(i_valid), 32'd0);
      int_req = '0; cyc(4);
      clear_err = 1'b1; cyc(1); clear_err = 1'b0;
      check("clear_to_idle", 32'(state_out), 32'd0);
      check("clear_count", 32'(count_out), 32'd0);
      check("clear_err_flag", 32'(err_flag), 32'd0);
      error_sig = 1'b0; cyc(4);

      // Step and interrupt on the same synchronised cycle: step is lost.
      int_req = 4'b0100; ctrl_step = 1'b1; exp_code_q.push_back(2'd2);
      cyc(2); int_req = '0; cyc(1);
      check("simul_int_ack", 32'(state_out), 32'd5);
      ctrl_step = 1'b0; cyc(6);
      check("simul_step_lost", 32'(state_out), 32'd0);
      check("simul_i_code", 32'(i_code), 32'd2);

      // Asynchronous reset mid-operation.
      strobe_step();
      strobe_count();
      check("pre_reset_wait", 32'(state_out), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_state", 32'(state_out), 32'd0);
      check("async_rst_count", 32'(count_out), 32'd0);
      @(negedge clk); rst_n = 1'b1; cyc(4);
      check("post_reset_idle", 32'(state_out), 32'd0);

      check("data_q_drained", 32'(exp_data_q.size()), 32'd0);
      check("code_q_drained", 32'(exp_code_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
